// File: rtl/fp_add_issue_ctrl.sv
// fp_add_issue_ctrl: operand-issue stage in front of a single-precision IEEE adder.
// Buffers operand pairs in a small FIFO, resolves NaN/Inf/zero cases locally,
// issues the remaining pairs to the adder, and returns results in order.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand stream handshake (in_ready is combinational)
//   in_a, in_b, in_op           operands (IEEE-754 single), 0 = A+B, 1 = A-B
//   number1, number2, op        registered operands to the adder
//   result                      adder result, sampled ADDER_LATENCY edges after issue
//   out_valid/out_ready         result stream handshake
//   out_result                  final IEEE-754 result
//   out_bypass                  result produced locally, adder not used
//   out_nan                     out_result is the canonical quiet NaN
module fp_add_issue_ctrl #(
  parameter int unsigned ADDER_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  output logic [31:0] number1,
  output logic [31:0] number2,
  output logic        op,
  input  logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_bypass,
  output logic        out_nan
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_W  = 4;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              op;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  entry_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [DATA_W-1:0]  r_number1;
  logic [DATA_W-1:0]  r_number2;
  logic               r_op;
  logic [DATA_W-1:0]  r_out_result;
  logic               r_out_valid;
  logic               r_out_bypass;
  logic               r_out_nan;

  entry_t             w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_issue;
  logic               w_bypass_load;
  logic               w_capture;
  logic               w_out_done;
  logic               w_special;
  logic               w_spec_nan;
  logic [DATA_W-1:0]  w_spec_result;
  logic               w_sb;
  logic               w_a_nan, w_a_inf, w_a_zero;
  logic               w_b_nan, w_b_inf, w_b_zero;

  assign in_ready = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push   = in_valid & in_ready;
  assign w_head   = r_mem[r_rd_ptr];

  // FIFO storage; data needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{a: in_a, b: in_b, op: in_op};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Special-case classification of the FIFO head, using B's effective sign
  always_comb begin
    w_sb          = w_head.b[31] ^ w_head.op;
    w_a_nan       = (&w_head.a[30:23]) & (|w_head.a[22:0]);
    w_a_inf       = (&w_head.a[30:23]) & ~(|w_head.a[22:0]);
    w_a_zero      = ~(|w_head.a[30:0]);
    w_b_nan       = (&w_head.b[30:23]) & (|w_head.b[22:0]);
    w_b_inf       = (&w_head.b[30:23]) & ~(|w_head.b[22:0]);
    w_b_zero      = ~(|w_head.b[30:0]);
    w_special     = 1'b1;
    w_spec_nan    = 1'b0;
    w_spec_result = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec_result = QNAN;
      w_spec_nan    = 1'b1;
    end else if (w_a_inf && w_b_inf) begin
      if (w_head.a[31] == w_sb) begin
        w_spec_result = w_head.a;
      end else begin
        w_spec_result = QNAN;
        w_spec_nan    = 1'b1;
      end
    end else if (w_a_inf) begin
      w_spec_result = w_head.a;
    end else if (w_b_inf) begin
      w_spec_result = {w_sb, w_head.b[30:0]};
    end else if (w_a_zero && w_b_zero) begin
      w_spec_result = {w_head.a[31] & w_sb, 31'b0};
    end else if (w_b_zero) begin
      w_spec_result = w_head.a;
    end else if (w_a_zero) begin
      w_spec_result = {w_sb, w_head.b[30:0]};
    end else begin
      w_special     = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and datapath strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_issue       = 1'b0;
    w_bypass_load = 1'b0;
    w_capture     = 1'b0;
    w_out_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_special) begin
            w_bypass_load = 1'b1;
            w_state_nxt   = ST_RESULT;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_lat_cnt == LAT_W'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          w_out_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Adder operands, latency counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_number1    <= '0;
      r_number2    <= '0;
      r_op         <= 1'b0;
      r_lat_cnt    <= '0;
      r_out_result <= '0;
      r_out_valid  <= 1'b0;
      r_out_bypass <= 1'b0;
      r_out_nan    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_number1 <= w_head.a;
        r_number2 <= w_head.b;
        r_op      <= w_head.op;
        r_lat_cnt <= LAT_W'(ADDER_LATENCY);
      end else if (r_state == ST_WAIT) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
      if (w_bypass_load) begin
        r_out_result <= w_spec_result;
        r_out_bypass <= 1'b1;
        r_out_nan    <= w_spec_nan;
        r_out_valid  <= 1'b1;
      end else if (w_capture) begin
        r_out_result <= result;
        r_out_bypass <= 1'b0;
        r_out_nan    <= 1'b0;
        r_out_valid  <= 1'b1;
      end else if (w_out_done) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign number1    = r_number1;
  assign number2    = r_number2;
  assign op         = r_op;
  assign out_result = r_out_result;
  assign out_valid  = r_out_valid;
  assign out_bypass = r_out_bypass;
  assign out_nan    = r_out_nan;

endmodule

// File: tb/tb_fp_add_issue_ctrl.sv
// Bench for fp_add_issue_ctrl: a latency-1 instance carries the directed and
// randomized traffic against a queue-based reference model; a latency-4
// instance covers mid-operation reset and the longer adder latency.
module tb_fp_add_issue_ctrl;

  localparam int unsigned LAT1  = 1;
  localparam int unsigned LAT4  = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] r;
    logic        byp;
    logic        nan;
  } exp_t;

  typedef enum int { C_NUM, C_ZERO, C_INF, C_NAN } cls_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance signals
  logic        rst_n, in_valid, in_ready, in_op, adder_op, out_valid, out_ready, out_bypass, out_nan;
  logic [31:0] in_a, in_b, number1, number2, result, out_result;
  logic        stub_fixed;

  // latency-4 instance signals
  logic        rst_n4, in_valid4, in_ready4, in_op4, adder_op4, out_valid4, out_ready4, out_bypass4, out_nan4;
  logic [31:0] in_a4, in_b4, number1_4, number2_4, result4, out_result4;
  logic [31:0] pipe4 [3];

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_push = 0;
  exp_t exp_q [$];

  fp_add_issue_ctrl #(.ADDER_LATENCY(LAT1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .number1(number1), .number2(number2), .op(adder_op), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_bypass(out_bypass), .out_nan(out_nan)
  );

  fp_add_issue_ctrl #(.ADDER_LATENCY(LAT4), .FIFO_DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_op(in_op4),
    .number1(number1_4), .number2(number2_4), .op(adder_op4), .result(result4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_result(out_result4),
    .out_bypass(out_bypass4), .out_nan(out_nan4)
  );

  // Stub adder: a scrambling function of the operands, not real arithmetic
  function automatic logic [31:0] stub(logic [31:0] a, logic [31:0] b, logic o, logic fixed);
    if (fixed) return 32'h3A51_C000;
    return a ^ {b[15:0], b[31:16]} ^ {31'b0, o} ^ 32'h5A5A_0F0F;
  endfunction

  // Latency-1 stub is combinational; latency-4 stub delays by three stages
  assign result = stub(number1, number2, adder_op, stub_fixed);
  always_ff @(posedge clk) begin
    pipe4[0] <= stub(number1_4, number2_4, adder_op4, 1'b0);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
  end
  assign result4 = pipe4[2];

  function automatic cls_e cls(logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? C_NAN : C_INF;
    if (x[30:0] == 0) return C_ZERO;
    return C_NUM;
  endfunction

  // Reference result for one operand pair
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic o, logic fixed);
    exp_t e;
    logic sb;
    logic [31:0] beff;
    cls_e ca, cb;
    sb   = b[31] ^ o;
    beff = {sb, b[30:0]};
    ca   = cls(a);
    cb   = cls(b);
    e    = '{r: 32'h0, byp: 1'b1, nan: 1'b0};
    if (ca == C_NAN || cb == C_NAN)        e = '{QNAN, 1'b1, 1'b1};
    else if (ca == C_INF && cb == C_INF)   e = (a[31] == sb) ? '{a, 1'b1, 1'b0} : '{QNAN, 1'b1, 1'b1};
    else if (ca == C_INF)                  e.r = a;
    else if (cb == C_INF)                  e.r = beff;
    else if (ca == C_ZERO && cb == C_ZERO) e.r = {a[31] & sb, 31'b0};
    else if (cb == C_ZERO)                 e.r = a;
    else if (ca == C_ZERO)                 e.r = beff;
    else                                   e = '{stub(a, b, o, fixed), 1'b0, 1'b0};
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One cycle on the latency-1 instance; scores handshakes seen before the edge
  task automatic tick();
    exp_t e;
    logic push, take;
    push = in_valid && in_ready;
    take = out_valid && out_ready;
    if (take) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_extra: observed %h expected no output", out_result);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", out_result, e.r);
        check("sb_bypass", 32'(out_bypass), 32'(e.byp));
        check("sb_nan", 32'(out_nan), 32'(e.nan));
      end
    end
    if (push) begin
      exp_q.push_back(model(in_a, in_b, in_op, stub_fixed));
      n_push++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick4();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single operation on an idle latency-1 instance with latency and value checks
  task automatic directed(string tag, logic [31:0] a, logic [31:0] b, logic o,
                          logic [31:0] er, logic eb, logic en);
    int lat;
    lat = eb ? 1 : 1 + int'(LAT1);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = o; out_ready = 1'b0;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      tick();
      check({tag, "_valid"}, 32'(out_valid), (i == lat) ? 32'd1 : 32'd0);
    end
    check({tag, "_result"}, out_result, er);
    check({tag, "_bypass"}, 32'(out_bypass), 32'(eb));
    check({tag, "_nan"}, 32'(out_nan), 32'(en));
    if (!eb) begin
      check({tag, "_number1"}, number1, a);
      check({tag, "_number2"}, number2, b);
      check({tag, "_op"}, 32'(adder_op), 32'(o));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] tbl [8];
    tbl = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
            32'h7FC0_0001, 32'h7F80_0001, 32'h0000_0001, 32'h3F80_0000};
    if ($urandom_range(2) == 0) return tbl[$urandom_range(7)];
    return $urandom;
  endfunction

  initial begin
    int guard;
    int seen;
    rst_n = 1'b0; rst_n4 = 1'b0; stub_fixed = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_op4 = 1'b0; out_ready4 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_number1", number1, 32'd0);
    check("rst_flags", {29'b0, adder_op, out_bypass, out_nan}, 32'd0);
    rst_n = 1'b1; rst_n4 = 1'b1;
    @(negedge clk);

    // adder path with fixed stub value
    stub_fixed = 1'b1;
    directed("add_fixed", 32'h40CB_0F28, 32'h40CB_089A, 1'b1, 32'h3A51_C000, 1'b0, 1'b0);
    stub_fixed = 1'b0;
    directed("add_hash", 32'h3F80_0000, 32'h4000_0000, 1'b0, stub(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0), 1'b0, 1'b0);
    directed("denorm", 32'h0000_0001, 32'h3F80_0000, 1'b1, stub(32'h0000_0001, 32'h3F80_0000, 1'b1, 1'b0), 1'b0, 1'b0);

    // zero, inf, nan and signed-zero bypasses
    directed("bzero", 32'h40E0_0000, 32'h0000_0000, 1'b0, 32'h40E0_0000, 1'b1, 1'b0);
    directed("azero", 32'h0000_0000, 32'h4000_0000, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    directed("inf_sub", 32'h7F80_0000, 32'h7F80_0000, 1'b1, QNAN, 1'b1, 1'b1);
    directed("inf_add", 32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    directed("nan_a", 32'h7FC0_0001, 32'h3F80_0000, 1'b0, QNAN, 1'b1, 1'b1);
    directed("binf_sub", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b1, 1'b0);
    directed("nzero_add", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
    directed("nzero_sub", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // backpressure: one op in the FSM plus a full FIFO
    n_push = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = $urandom; in_b = $urandom; in_op = 1'($urandom_range(1));
      tick();
    end
    check("bp_accepted", 32'(n_push), 32'(DEPTH + 1));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_still_full", 32'(in_ready), 32'd0);
    tick();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
      tick();
      guard++;
    end
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(1));
      in_a      = rand_operand();
      in_b      = rand_operand();
      in_op     = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
      tick();
      guard++;
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_idle", 32'(out_valid), 32'd0);

    // latency-4 instance: reset while waiting with two entries queued
    in_valid4 = 1'b1; in_op4 = 1'b0; in_b4 = 32'h4000_0000;
    in_a4 = 32'h3F80_0000; tick4();
    in_a4 = 32'h4040_0000; tick4();
    in_a4 = 32'h4080_0000; tick4();
    in_valid4 = 1'b0;
    check("l4_issued", number1_4, 32'h3F80_0000);
    check("l4_wait_valid", 32'(out_valid4), 32'd0);
    #2;
    rst_n4 = 1'b0;
    #1;
    check("l4_rst_valid", 32'(out_valid4), 32'd0);
    check("l4_rst_ready", 32'(in_ready4), 32'd1);
    check("l4_rst_number1", number1_4, 32'd0);
    @(negedge clk);
    rst_n4 = 1'b1;
    out_ready4 = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick4();
      if (out_valid4) seen++;
    end
    check("l4_no_stale", 32'(seen), 32'd0);

    // fresh operation after reset, full adder latency
    in_valid4 = 1'b1; in_a4 = 32'h4120_0000; in_b4 = 32'h3F00_0000; in_op4 = 1'b1; out_ready4 = 1'b0;
    tick4();
    in_valid4 = 1'b0;
    for (int i = 1; i <= 1 + int'(LAT4); i++) begin
      tick4();
      check("l4_valid", 32'(out_valid4), (i == 1 + int'(LAT4)) ? 32'd1 : 32'd0);
    end
    check("l4_result", out_result4, stub(32'h4120_0000, 32'h3F00_0000, 1'b1, 1'b0));
    check("l4_bypass", 32'(out_bypass4), 32'd0);
    out_ready4 = 1'b1;
    tick4();
    check("l4_done", 32'(out_valid4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_add_issue_ctrl.md
Name: fp_add_issue_ctrl

Overview:
Upstream operand-issue stage for the single-precision IEEE_adder.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Resolves IEEE special cases (NaN, Inf, zero) locally. All other pairs drive IEEE_adder's number1/number2/op, wait a fixed adder latency, and capture its result.
- Presents each result on a valid/ready output stream, in order, one operation in flight at a time.

Parameters:
ADDER_LATENCY, 1, clk rising edges from the edge that registers number1/number2/op to the edge that samples result; legal range 1-15.
FIFO_DEPTH, 4, input operand FIFO entries; power of two, 2-16.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO not full (combinational)
in_a  input  32  operand A, IEEE-754 single
in_b  input  32  operand B, IEEE-754 single
in_op  input  1  0 = A+B, 1 = A-B
number1  output  32  to IEEE_adder number1 (registered)
number2  output  32  to IEEE_adder number2 (registered)
op  output  1  to IEEE_adder op (registered)
result  input  32  from IEEE_adder result
out_valid  output  1  out_result valid
out_ready  input  1  downstream accepts
out_result  output  32  final IEEE-754 result
out_bypass  output  1  result produced locally, adder not used
out_nan  output  1  out_result is canonical qNaN

Behaviour:
Reset (rst_n low, asynchronous):
- FIFO empties; FSM goes to IDLE.
- number1, number2, op, out_result, out_valid, out_bypass, out_nan all clear to 0.
- in_ready = 1 during and after reset, since FIFO count is 0.
- Reset mid-operation discards FIFO contents and any in-flight op; no output is produced for them.

FIFO push and pop:
- Push on edge where in_valid & in_ready; in_ready = (count != FIFO_DEPTH), with no bypass when full.
- Pop only in IDLE when count != 0.
- A push and a pop on the same edge leave count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Classification, computed combinationally on the FIFO head, with effective sign sb' = sign(b) XOR op:
1. Either operand NaN (exp=FF, mant!=0): result 0x7FC00000, nan=1.
2. Both operands Inf: if sign(a)==sb', result is that Inf; otherwise result 0x7FC00000, nan=1.
3. One operand Inf: result is a if a is Inf, else {sb', b[30:0]}.
4. Both operands zero (exp=0, mant=0): result {sign(a) & sb', 31'b0}.
5. b zero: result a. a zero: result {sb', b[30:0]}.
6. Otherwise: go to the adder.
- Denormals (exp=0, mant!=0) are not zero and go to the adder.

FSM:
- IDLE: when count != 0, pop.
  - Special case: load out_result, set out_bypass=1 and out_nan, go to RESULT. number1/number2/op are unchanged.
  - Otherwise: register number1=a, number2=b, op=in_op; load cnt=ADDER_LATENCY; go to WAIT.
- WAIT: cnt decrements each edge. On the edge where cnt==1, capture out_result<=result, set out_bypass=0 and out_nan=0, go to RESULT.
- RESULT: out_valid=1; out_result/out_bypass/out_nan are held stable until the handshake. On out_valid & out_ready, go to IDLE. No pop occurs on that edge.

Timing and ordering:
- Latency from the pop edge P: bypass gives out_valid high after P. Adder path gives out_valid high after edge P+ADDER_LATENCY.
- number1/number2/op hold their last issued values between operations.
- Results are strictly in input order.
- out_ready is ignored outside RESULT.

Test Plan:
1. Adder path, ADDER_LATENCY=1, stub adder returns 0x3A51C000: push a=0x40CB0F28, b=0x40CB089A, op=1 at edge 0 -> number1/number2/op registered after edge 1; out_valid after edge 2; out_result=0x3A51C000, out_bypass=0.
2. Zero bypass:
   - a=0x40E00000, b=0x00000000, op=0 -> out_result=0x40E00000, bypass=1, out_valid after pop edge.
   - a=0x00000000, b=0x40000000, op=1 -> 0xC0000000.
3. Inf/NaN:
   - 0x7F800000 - 0x7F800000 -> 0x7FC00000, out_nan=1.
   - 0x7F800000 + 0x7F800000 -> 0x7F800000.
   - 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
4. Signed zeros:
   - 0x80000000 + 0x80000000 -> 0x80000000.
   - 0x80000000 - 0x80000000 -> 0x00000000.
5. Backpressure, FIFO_DEPTH=4, out_ready=0, in_valid held high -> exactly 5 pairs accepted (1 in FSM + 4 in FIFO), then in_ready=0. Release out_ready -> 5 results in order; in_ready returns 1 after the next pop.
6. Reset mid-WAIT with ADDER_LATENCY=4 and 2 entries queued: assert rst_n low between edges -> out_valid=0 and in_ready=1 immediately. After release, no stale outputs appear and a fresh push completes normally.
